// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared definitions for the divider-sharing controller.
//   state_t : controller FSM state (IDLE / BUSY / DONE)
//   clog2   : ceiling log2, used for requester-index and counter widths
package div_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/division.sv
// division: purely combinational unsigned divider.
//   a   : dividend
//   b   : divisor
//   Res : quotient  (all ones when b == 0)
//   rem : remainder (equals a when b == 0)
// The divide-by-zero result mirrors what a restoring divider array produces,
// so the value is defined rather than left to the synthesis tool.
module division #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] Res,
    output logic [WIDTH-1:0] rem
);

    always_comb begin
        Res = '1;
        rem = a;
        if (b != '0) begin
            Res = a / b;
            rem = a % b;
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant.
//   req   : request vector, one bit per requester
//   ptr   : highest-priority requester index this round
//   grant : one-hot grant (zero when no request)
// The search starts at ptr and wraps, so the first active requester at or
// after ptr wins.
module rr_arbiter
    import div_ctrl_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = (clog2(NREQ) < 1) ? 1 : clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant
);

    logic           found;
    logic [IDW-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_share_ctrl.sv
// div_share_ctrl: shares one combinational divider between NREQ requesters.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   req_valid/ready   : per-requester handshake (ready is one-hot or zero)
//   req_a, req_b      : packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/ready   : shared response handshake
//   rsp_id            : requester index of the response
//   rsp_q, rsp_r      : quotient / remainder
//   rsp_dz            : divide-by-zero flag (0 unless bypass is compiled in)
//   dbg_state         : current FSM state
//   dbg_rr_ptr        : current round-robin pointer
//
// Handshake rule: a transfer happens on a rising clk edge where valid and
// ready are both high; valid, once raised, holds with its payload stable
// until that transfer.
//
// Build option: DIVCTL_ZERO_BYPASS_EN -- a zero divisor skips the divider and
// answers in one cycle with q=all ones, r=a, rsp_dz=1.
module div_share_ctrl
    import div_ctrl_pkg::*;
#(
    parameter  int WIDTH      = 8,
    parameter  int NREQ       = 4,
    parameter  int DIV_CYCLES = 2,
    localparam int IDW        = (clog2(NREQ) < 1) ? 1 : clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_q,
    output logic [WIDTH-1:0]      rsp_r,
    output logic                  rsp_dz,
    output state_t                dbg_state,
    output logic [IDW-1:0]        dbg_rr_ptr
);

    localparam int CNTW = (DIV_CYCLES > 1) ? clog2(DIV_CYCLES) : 1;
    localparam logic [CNTW-1:0] CNT_INIT = CNTW'(DIV_CYCLES - 1);

    state_t           state_q;
    state_t           state_d;
    logic [IDW-1:0]   rr_ptr;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [IDW-1:0]   id_reg;
    logic [CNTW-1:0]  cnt;

    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_idx;
    logic [WIDTH-1:0] grant_a;
    logic [WIDTH-1:0] grant_b;
    logic             accept;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] div_r;

    logic [WIDTH-1:0] a_arr [NREQ];
    logic [WIDTH-1:0] b_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
        assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
    end

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) grant_idx = IDW'(i);
        end
    end

    assign grant_a = a_arr[grant_idx];
    assign grant_b = b_arr[grant_idx];

    // The divider only ever sees the registered operands, so its output
    // settles during BUSY regardless of what the requesters do meanwhile.
    division #(.WIDTH(WIDTH)) u_div (
        .a   (a_reg),
        .b   (b_reg),
        .Res (div_q),
        .rem (div_r)
    );

`ifdef DIVCTL_ZERO_BYPASS_EN
    logic bypass;
    assign bypass = (grant_b == '0);
`else
    assign rsp_dz = 1'b0;
`endif

    // Next state and request-side ready.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = grant;
                if (|grant) begin
                    accept  = 1'b1;
                    state_d = BUSY;
`ifdef DIVCTL_ZERO_BYPASS_EN
                    if (bypass) state_d = DONE;
`endif
                end
            end
            BUSY: begin
                if (cnt == '0) state_d = DONE;
            end
            DONE: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_ptr    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            id_reg    <= '0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_q     <= '0;
            rsp_r     <= '0;
`ifdef DIVCTL_ZERO_BYPASS_EN
            rsp_dz    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_reg  <= grant_a;
                        b_reg  <= grant_b;
                        id_reg <= grant_idx;
                        cnt    <= CNT_INIT;
                        rr_ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
`ifdef DIVCTL_ZERO_BYPASS_EN
                        if (bypass) begin
                            rsp_valid <= 1'b1;
                            rsp_id    <= grant_idx;
                            rsp_q     <= '1;
                            rsp_r     <= grant_a;
                            rsp_dz    <= 1'b1;
                        end
`endif
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= id_reg;
                        rsp_q     <= div_q;
                        rsp_r     <= div_r;
`ifdef DIVCTL_ZERO_BYPASS_EN
                        rsp_dz    <= 1'b0;
`endif
                    end
                end
                DONE: begin
                    // Response fields keep their last value after the handshake.
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign dbg_state  = state_q;
    assign dbg_rr_ptr = rr_ptr;

endmodule

// File: tb/tb_div_share_ctrl.sv
// tb_div_share_ctrl: self-checking bench for div_share_ctrl (default
// parameters). Expectations follow DIVCTL_ZERO_BYPASS_EN when it is defined.
module tb_div_share_ctrl;
  import div_ctrl_pkg::*;

  localparam int WIDTH      = 8;
  localparam int NREQ       = 4;
  localparam int DIV_CYCLES = 2;
  localparam int IDW        = 2;
  localparam int EW         = 1 + IDW + 2 * WIDTH;
`ifdef DIVCTL_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b1;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_q;
  logic [WIDTH-1:0]      rsp_r;
  logic                  rsp_dz;
  state_t                dbg_state;
  logic [IDW-1:0]        dbg_rr_ptr;

  logic [WIDTH-1:0] drv_a [NREQ];
  logic [WIDTH-1:0] drv_b [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_pack
    assign req_a[i*WIDTH +: WIDTH] = drv_a[i];
    assign req_b[i*WIDTH +: WIDTH] = drv_b[i];
  end

  div_share_ctrl #(.WIDTH(WIDTH), .NREQ(NREQ), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_q      (rsp_q),
    .rsp_r      (rsp_r),
    .rsp_dz     (rsp_dz),
    .dbg_state  (dbg_state),
    .dbg_rr_ptr (dbg_rr_ptr)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] m_last;
  bit            m_busy;
  int            m_due;
  int            m_ptr;
  int            now;
  int            acc;
  int            acc_now;
  int            rise_now;
  logic [WIDTH-1:0] rise_q, rise_r;
  logic          rise_dz;
  logic          prev_valid;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] ref_rsp(input int id, input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] q, r;
    logic dz;
    if (b == 0) begin
      q  = '1;
      r  = a;
      dz = BYPASS;
    end else begin
      q  = a / b;
      r  = a % b;
      dz = 1'b0;
    end
    return {dz, IDW'(id), q, r};
  endfunction

  function automatic int ref_lat(input logic [WIDTH-1:0] b);
    if (BYPASS && b == 0) return 1;
    return DIV_CYCLES + 1;
  endfunction

  function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (ptr + k) % NREQ;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  // One clock cycle: check outputs at negedge against the model, advance the
  // model by this cycle's handshakes, then return just after the next posedge.
  task automatic tick();
    logic [NREQ-1:0] exp_rdy;
    logic [EW-1:0]   got;
    int g;
    @(negedge clk);
    exp_rdy = '0;
    g = -1;
    if (!m_busy) begin
      g = pick(req_valid, m_ptr);
      if (g >= 0) exp_rdy[g] = 1'b1;
    end
    check("req_ready", req_ready, exp_rdy);
    check("rr_ptr", dbg_rr_ptr, m_ptr);
    got = {rsp_dz, rsp_id, rsp_q, rsp_r};
    if (m_busy && now >= m_due) begin
      check("rsp_valid_hi", rsp_valid, 1'b1);
      check("rsp_fields", got, exp_q[0]);
      check("state_done", dbg_state, DONE);
    end else begin
      check("rsp_valid_lo", rsp_valid, 1'b0);
      check("rsp_hold", got, m_last);
      check("state", dbg_state, m_busy ? BUSY : IDLE);
    end
    if (rsp_valid && !prev_valid) begin
      rise_now = now;
      rise_q   = rsp_q;
      rise_r   = rsp_r;
      rise_dz  = rsp_dz;
    end
    prev_valid = rsp_valid;
    acc = -1;
    if (g >= 0) begin
      exp_q.push_back(ref_rsp(g, drv_a[g], drv_b[g]));
      m_busy  = 1'b1;
      m_due   = now + ref_lat(drv_b[g]);
      m_ptr   = (g + 1) % NREQ;
      acc     = g;
      acc_now = now;
    end else if (m_busy && now >= m_due && rsp_ready) begin
      m_last = exp_q.pop_front();
      m_busy = 1'b0;
    end
    now++;
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic model_reset();
    m_busy     = 1'b0;
    m_ptr      = 0;
    m_last     = '0;
    prev_valid = 1'b0;
    rise_now   = -1;
    exp_q.delete();
  endtask

  task automatic do_reset(input int cycles);
    rst       = 1'b1;
    req_valid = '0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    check({tag, "_rsp_q"}, rsp_q, 0);
    check({tag, "_rsp_r"}, rsp_r, 0);
    check({tag, "_rsp_id"}, rsp_id, 0);
    check({tag, "_rsp_dz"}, rsp_dz, 1'b0);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_state"}, dbg_state, IDLE);
    check({tag, "_rr_ptr"}, dbg_rr_ptr, 0);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic issue(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    drv_a[id] = a;
    drv_b[id] = b;
    req_valid[id] = 1'b1;
    for (int k = 0; k < 20 && req_valid[id]; k++) begin
      tick();
      if (acc == id) req_valid[id] = 1'b0;
    end
    check("accept_timeout", req_valid[id], 1'b0);
    req_valid[id] = 1'b0;
  endtask

  task automatic single_op(input string tag, input int id, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input int exp_lat,
                           input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                           input logic edz);
    rise_now = -1;
    issue(id, a, b);
    run(6);
    check({tag, "_latency"}, rise_now - acc_now, exp_lat);
    check({tag, "_q"}, rise_q, eq);
    check({tag, "_r"}, rise_r, er);
    check({tag, "_dz"}, rise_dz, edz);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int order[$];
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < NREQ; i++) begin
      drv_a[i] = '0;
      drv_b[i] = 8'd1;
    end
    now = 0;

    // Reset state
    do_reset(3);
    check_reset_values("reset");

    // Single operations
    rsp_ready = 1'b1;
    single_op("op_100_10", 0, 8'd100, 8'd10, 3, 8'd10, 8'd0, 1'b0);
    single_op("op_16_3", 0, 8'd16, 8'd3, 3, 8'd5, 8'd1, 1'b0);
    single_op("op_255_5", 0, 8'd255, 8'd5, 3, 8'd51, 8'd0, 1'b0);

    // Fairness: all four requesting, requester 0 stays asserted
    do_reset(2);
    drv_a[0] = 8'd100; drv_b[0] = 8'd10;
    drv_a[1] = 8'd200; drv_b[1] = 8'd40;
    drv_a[2] = 8'd90;  drv_b[2] = 8'd9;
    drv_a[3] = 8'd70;  drv_b[3] = 8'd10;
    req_valid = 4'b1111;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (acc >= 0) begin
        order.push_back(acc);
        if (acc != 0 || order.size() >= 5) req_valid[acc] = 1'b0;
      end
    end
    req_valid = '0;
    check("fair_count", order.size(), 5);
    for (int k = 0; k < 5 && k < order.size(); k++) check("fair_order", order[k], exp_order[k]);

    // Backpressure with a pending second requester
    do_reset(2);
    rsp_ready = 1'b0;
    drv_a[0] = 8'd100; drv_b[0] = 8'd10;
    drv_a[1] = 8'd16;  drv_b[1] = 8'd3;
    req_valid = 4'b0011;
    for (int k = 0; k < 10 && rise_now < 0; k++) begin
      tick();
      if (acc == 0) req_valid[0] = 1'b0;
    end
    check("bp_rsp_seen", rise_now >= 0, 1'b1);
    run(4);
    check("bp_hold_q", rsp_q, 8'd10);
    check("bp_hold_id", rsp_id, 0);
    rsp_ready = 1'b1;
    tick();
    tick();
    check("bp_accept1", acc, 1);
    req_valid[1] = 1'b0;
    run(6);

    // Reset in the cycle after an accept
    do_reset(2);
    issue(0, 8'd255, 8'd5);
    do_reset(1);
    check_reset_values("midrst");
    run(8);

    // Divide by zero
    do_reset(2);
    single_op("dz_42_0", 0, 8'd42, 8'd0, BYPASS ? 1 : 3, 8'd255, 8'd42, BYPASS);

    // Pointer wrap
    do_reset(2);
    issue(3, 8'd9, 8'd2);
    check("wrap_grant3", acc, 3);
    run(5);
    check("wrap_ptr0", dbg_rr_ptr, 0);
    issue(0, 8'd9, 8'd4);
    check("wrap_grant0", acc, 0);
    run(5);
    check("wrap_ptr1", dbg_rr_ptr, 1);

    // Randomized traffic
    do_reset(2);
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          drv_a[i] = WIDTH'($urandom_range(0, 255));
          drv_b[i] = ($urandom_range(0, 7) == 0) ? 8'd0 : WIDTH'($urandom_range(1, 255));
          req_valid[i] = 1'b1;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (acc >= 0) req_valid[acc] = 1'b0;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    run(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
    $fatal(1);
  end

endmodule
